// File: rtl/sm83_pkg.sv
// Shared types and address-map constants for the sm83 memory-side bus responder.
package sm83_pkg;

  typedef enum logic [2:0] {
    REG_EXT,
    REG_ECHO,
    REG_HRAM,
    REG_IE,
    REG_UNMAPPED
  } bus_region_t;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_EXT_WAIT,
    BUS_RESP
  } bus_state_t;

  localparam logic [15:0] HRAM_BASE   = 16'hFF80;
  localparam logic [15:0] IE_ADDR     = 16'hFFFF;
  localparam logic [15:0] ECHO_BASE   = 16'hE000;
  localparam logic [15:0] ECHO_END    = 16'hFDFF;
  localparam logic [15:0] UNMAP_BASE  = 16'hFEA0;
  localparam logic [15:0] UNMAP_END   = 16'hFEFF;
  localparam logic [15:0] ECHO_OFFSET = 16'h2000;
  localparam logic [7:0]  OPEN_BUS    = 8'hFF;

  // FE00-FE9F and FF00-FF7F fall through to EXT together with 0000-DFFF.
  function automatic bus_region_t decode_region(input logic [15:0] addr, input logic echo_en);
    bus_region_t region;
    if (addr == IE_ADDR)
      region = REG_IE;
    else if (addr >= HRAM_BASE)
      region = REG_HRAM;
    else if (addr >= UNMAP_BASE && addr <= UNMAP_END)
      region = REG_UNMAPPED;
    else if (addr >= ECHO_BASE && addr <= ECHO_END)
      region = echo_en ? REG_ECHO : REG_UNMAPPED;
    else
      region = REG_EXT;
    return region;
  endfunction

endpackage

// File: rtl/sm83_hram.sv
// 127-byte high RAM: synchronous write, registered read, contents not reset.
module sm83_hram (
  input  logic       clk,
  input  logic       we,
  input  logic       re,
  input  logic [6:0] idx,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [0:126];

  always_ff @(posedge clk) begin
    if (we)
      mem[idx] <= wdata;
    if (re)
      rdata <= mem[idx];
  end

endmodule

// File: rtl/sm83_bus_responder.sv
// Byte-bus responder: serves HRAM/IE internally, forwards the rest of the DMG map
// over a req/ack handshake with timeout, answers unmapped space with open bus.
module sm83_bus_responder
  import sm83_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter bit ECHO_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [7:0]  cpu_rdata,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata,
  output logic [7:0]  ie_reg,
  output logic        bus_err,
  input  logic        err_clr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);
  localparam logic [6:0] HRAM_IDX_OFS = HRAM_BASE[6:0];

  bus_state_t  state, next_state;
  bus_region_t region;
  logic [CW-1:0] count;
  logic [7:0]  rdata_q;
  logic [7:0]  hram_rdata;
  logic        hram_sel;
  logic        accept;
  logic        timeout_hit;
  logic        hram_we, hram_re;

  assign region      = decode_region(cpu_addr, ECHO_EN);
  assign accept      = (state == BUS_IDLE) && cpu_req;
  assign timeout_hit = (count == LAST_COUNT);
  assign hram_we     = accept && (region == REG_HRAM) && cpu_we;
  assign hram_re     = accept && (region == REG_HRAM) && !cpu_we;

  // HRAM read data lands in the array's own output register, so the read
  // result is muxed from there until some other read completion replaces it.
  assign cpu_rdata = hram_sel ? hram_rdata : rdata_q;

  sm83_hram u_hram (
    .clk   (clk),
    .we    (hram_we),
    .re    (hram_re),
    .idx   (cpu_addr[6:0] - HRAM_IDX_OFS),
    .wdata (cpu_wdata),
    .rdata (hram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= BUS_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    cpu_busy   = (state != BUS_IDLE);
    cpu_done   = 1'b0;
    unique case (state)
      BUS_IDLE: begin
        if (cpu_req)
          next_state = (region == REG_EXT || region == REG_ECHO) ? BUS_EXT_WAIT : BUS_RESP;
      end
      BUS_EXT_WAIT: begin
        if (ext_ack || timeout_hit)
          next_state = BUS_RESP;
      end
      BUS_RESP: begin
        cpu_done   = 1'b1;
        next_state = BUS_IDLE;
      end
      default: next_state = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= 16'h0000;
      ext_wdata <= 8'h00;
      count     <= '0;
      rdata_q   <= 8'h00;
      hram_sel  <= 1'b0;
      ie_reg    <= 8'h00;
      bus_err   <= 1'b0;
    end else begin
      if (err_clr)
        bus_err <= 1'b0;
      unique case (state)
        BUS_IDLE: begin
          if (cpu_req) begin
            unique case (region)
              REG_EXT, REG_ECHO: begin
                ext_addr  <= (region == REG_ECHO) ? cpu_addr - ECHO_OFFSET : cpu_addr;
                ext_we    <= cpu_we;
                ext_wdata <= cpu_wdata;
                ext_req   <= 1'b1;
                count     <= '0;
              end
              REG_IE: begin
                if (cpu_we) begin
                  ie_reg <= cpu_wdata;
                end else begin
                  rdata_q  <= ie_reg;
                  hram_sel <= 1'b0;
                end
              end
              REG_HRAM: begin
                if (!cpu_we)
                  hram_sel <= 1'b1;
              end
              default: begin
                if (!cpu_we) begin
                  rdata_q  <= OPEN_BUS;
                  hram_sel <= 1'b0;
                end
              end
            endcase
          end
        end
        BUS_EXT_WAIT: begin
          if (ext_ack) begin
            ext_req <= 1'b0;
            if (!ext_we) begin
              rdata_q  <= ext_rdata;
              hram_sel <= 1'b0;
            end
          end else if (timeout_hit) begin
            // Timeout set overrides a coincident err_clr.
            ext_req <= 1'b0;
            bus_err <= 1'b1;
            if (!ext_we) begin
              rdata_q  <= OPEN_BUS;
              hram_sel <= 1'b0;
            end
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Self-checking bench for sm83_bus_responder: table of directed accesses plus
// hand-written sequences for busy-ignore, error clear and mid-transaction reset.
module tb_sm83_bus_responder;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic [7:0]  cpu_rdata;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_ack;
  logic [7:0]  ext_rdata;
  logic [7:0]  ie_reg;
  logic        bus_err;
  logic        err_clr;

  int tests_run = 0;
  int tests_failed = 0;

  sm83_bus_responder #(.TIMEOUT(16), .ECHO_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_busy  (cpu_busy),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_ack   (ext_ack),
    .ext_rdata (ext_rdata),
    .ie_reg    (ie_reg),
    .bus_err   (bus_err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          ack_delay;
    logic [7:0]  ext_rd;
    int          exp_lat;
    logic        exp_ext;
    logic [15:0] exp_ext_addr;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_ie;
  } vec_t;

  vec_t vecs [16];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One CPU access; ack_delay < 0 means the external side never acknowledges.
  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                               input int ack_delay, input logic [7:0] ext_rd, input logic hold_req,
                               output int lat, output logic saw_ext, output logic [15:0] seen_addr,
                               output logic seen_we, output logic [7:0] seen_wdata);
    int waits;
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(posedge clk); #1;
    if (!hold_req) cpu_req = 1'b0;
    lat = 1;
    waits = 0;
    saw_ext = 1'b0;
    seen_addr = 16'h0;
    seen_we = 1'b0;
    seen_wdata = 8'h0;
    while (!cpu_done && lat < 200) begin
      if (ext_req) begin
        saw_ext    = 1'b1;
        seen_addr  = ext_addr;
        seen_we    = ext_we;
        seen_wdata = ext_wdata;
        ext_ack    = (ack_delay >= 0) && (waits == ack_delay);
        ext_rdata  = ext_rd;
        waits++;
      end
      @(posedge clk); #1;
      ext_ack = 1'b0;
      lat++;
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic        saw_ext;
    logic [15:0] seen_addr;
    logic        seen_we;
    logic [7:0]  seen_wdata;
    int          extra_done;
    int          extra_req;

    //          we    addr      wd     ack  ext_rd lat ext  ext_addr  rdata  err   ie
    vecs[0]  = '{1'b1, 16'hFF80, 8'h5A, -1, 8'h00, 1,  1'b0, 16'h0000, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 16'hFF80, 8'h00, -1, 8'h00, 1,  1'b0, 16'h0000, 8'h5A, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 16'hFFFF, 8'h1F, -1, 8'h00, 1,  1'b0, 16'h0000, 8'h5A, 1'b0, 8'h1F};
    vecs[3]  = '{1'b0, 16'hFFFF, 8'h00, -1, 8'h00, 1,  1'b0, 16'h0000, 8'h1F, 1'b0, 8'h1F};
    vecs[4]  = '{1'b0, 16'hE123, 8'h00,  3, 8'hC3, 5,  1'b1, 16'hC123, 8'hC3, 1'b0, 8'h1F};
    vecs[5]  = '{1'b1, 16'hFEA5, 8'h77, -1, 8'h00, 1,  1'b0, 16'h0000, 8'hC3, 1'b0, 8'h1F};
    vecs[6]  = '{1'b0, 16'hFEA5, 8'h00, -1, 8'h00, 1,  1'b0, 16'h0000, 8'hFF, 1'b0, 8'h1F};
    vecs[7]  = '{1'b1, 16'hFFFE, 8'hA5, -1, 8'h00, 1,  1'b0, 16'h0000, 8'hFF, 1'b0, 8'h1F};
    vecs[8]  = '{1'b0, 16'hFFFE, 8'h00, -1, 8'h00, 1,  1'b0, 16'h0000, 8'hA5, 1'b0, 8'h1F};
    vecs[9]  = '{1'b1, 16'hC000, 8'h11,  0, 8'h00, 2,  1'b1, 16'hC000, 8'hA5, 1'b0, 8'h1F};
    vecs[10] = '{1'b0, 16'hFDFF, 8'h00,  0, 8'h42, 2,  1'b1, 16'hDDFF, 8'h42, 1'b0, 8'h1F};
    vecs[11] = '{1'b0, 16'hFE9F, 8'h00,  1, 8'h99, 3,  1'b1, 16'hFE9F, 8'h99, 1'b0, 8'h1F};
    vecs[12] = '{1'b0, 16'hFF7F, 8'h00,  0, 8'h24, 2,  1'b1, 16'hFF7F, 8'h24, 1'b0, 8'h1F};
    vecs[13] = '{1'b0, 16'hFF80, 8'h00, -1, 8'h00, 1,  1'b0, 16'h0000, 8'h5A, 1'b0, 8'h1F};
    vecs[14] = '{1'b0, 16'hDFFF, 8'h00,  2, 8'h6B, 4,  1'b1, 16'hDFFF, 8'h6B, 1'b0, 8'h1F};
    vecs[15] = '{1'b0, 16'h0100, 8'h00, -1, 8'h00, 17, 1'b1, 16'h0100, 8'hFF, 1'b1, 8'h1F};

    rst_n = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = 16'h0;
    cpu_wdata = 8'h0;
    ext_ack = 1'b0;
    ext_rdata = 8'h0;
    err_clr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset cpu_busy", 32'(cpu_busy), 0);
    checkOutput("reset cpu_done", 32'(cpu_done), 0);
    checkOutput("reset ext_req", 32'(ext_req), 0);
    checkOutput("reset ext_we", 32'(ext_we), 0);
    checkOutput("reset bus_err", 32'(bus_err), 0);
    checkOutput("reset cpu_rdata", 32'(cpu_rdata), 0);
    checkOutput("reset ext_addr", 32'(ext_addr), 0);
    checkOutput("reset ext_wdata", 32'(ext_wdata), 0);
    checkOutput("reset ie_reg", 32'(ie_reg), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ack_delay, vecs[i].ext_rd,
                    1'b0, lat, saw_ext, seen_addr, seen_we, seen_wdata);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("vec%0d ext_req seen", i), 32'(saw_ext), 32'(vecs[i].exp_ext));
      checkOutput($sformatf("vec%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].exp_rdata));
      checkOutput($sformatf("vec%0d bus_err", i), 32'(bus_err), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d ie_reg", i), 32'(ie_reg), 32'(vecs[i].exp_ie));
      if (vecs[i].exp_ext) begin
        checkOutput($sformatf("vec%0d ext_addr", i), 32'(seen_addr), 32'(vecs[i].exp_ext_addr));
        checkOutput($sformatf("vec%0d ext_we", i), 32'(seen_we), 32'(vecs[i].we));
        if (vecs[i].we)
          checkOutput($sformatf("vec%0d ext_wdata", i), 32'(seen_wdata), 32'(vecs[i].wdata));
      end
    end

    // bus_err is sticky until err_clr
    @(posedge clk); #1;
    checkOutput("bus_err sticky", 32'(bus_err), 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checkOutput("bus_err cleared", 32'(bus_err), 0);

    // cpu_req held high while busy must not start a second access
    applyStimulus(1'b0, 16'h0100, 8'h00, 2, 8'h5E, 1'b1, lat, saw_ext, seen_addr, seen_we, seen_wdata);
    checkOutput("busy latency", 32'(lat), 4);
    checkOutput("busy cpu_rdata", 32'(cpu_rdata), 32'h5E);
    extra_done = 0;
    extra_req = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (cpu_done) extra_done++;
      if (ext_req) extra_req++;
    end
    checkOutput("busy extra cpu_done", 32'(extra_done), 0);
    checkOutput("busy extra ext_req", 32'(extra_req), 0);
    checkOutput("busy idle afterwards", 32'(cpu_busy), 0);

    // Reset in the middle of an external wait
    @(posedge clk); #1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 16'h0100;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre-reset ext_req", 32'(ext_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset ext_req", 32'(ext_req), 0);
    checkOutput("mid-reset cpu_busy", 32'(cpu_busy), 0);
    checkOutput("mid-reset cpu_done", 32'(cpu_done), 0);
    checkOutput("mid-reset ie_reg", 32'(ie_reg), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    extra_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (cpu_done) extra_done++;
    end
    checkOutput("post-reset cpu_done", 32'(extra_done), 0);

    applyStimulus(1'b1, 16'h8000, 8'h3C, 1, 8'h00, 1'b0, lat, saw_ext, seen_addr, seen_we, seen_wdata);
    checkOutput("post-reset write latency", 32'(lat), 3);
    checkOutput("post-reset ext_req seen", 32'(saw_ext), 1);
    checkOutput("post-reset ext_addr", 32'(seen_addr), 32'h8000);
    checkOutput("post-reset ext_we", 32'(seen_we), 1);
    checkOutput("post-reset ext_wdata", 32'(seen_wdata), 32'h3C);
    checkOutput("post-reset cpu_rdata", 32'(cpu_rdata), 0);
    checkOutput("post-reset bus_err", 32'(bus_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sm83_bus_responder.md
Name: sm83_bus_responder

Overview:
Memory-side responder for the sm83 core's byte bus. It accepts single-byte read/write requests issued by the core's control sequencer (IR fetch, operand-to-Z, r8/Z-to-mem) and decodes the 16-bit address into the DMG map. HRAM and the IE register are served internally. Echo, cartridge, VRAM, WRAM, OAM and IO accesses are forwarded over a req/ack handshake with a timeout. Unmapped accesses complete immediately.

Parameters:
TIMEOUT, 16, max cycles ext_req stays high without ext_ack before forced completion (>=1)
ECHO_EN, 1, 1: E000-FDFF aliases to C000-DDFF on ext bus; 0: treated as unmapped

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  request strobe, accepted when cpu_busy=0
cpu_we  in  1  1=write, 0=read (sampled with cpu_req)
cpu_addr  in  16  byte address (sampled with cpu_req)
cpu_wdata  in  8  write data (sampled with cpu_req)
cpu_busy  out  1  responder not idle; core must stall
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  8  read data, valid when cpu_done=1 for a read
ext_req  out  1  external access request
ext_we  out  1  external write enable
ext_addr  out  16  external address (echo already translated)
ext_wdata  out  8  external write data
ext_ack  in  1  external completion; ignored when ext_req=0
ext_rdata  in  8  external read data, sampled on ext_ack
ie_reg  out  8  IE register (FFFF) for the interrupt controller
bus_err  out  1  sticky timeout flag
err_clr  in  1  clears bus_err

Behaviour:
- Reset (async, rst_n=0): state IDLE. cpu_busy, cpu_done, ext_req, ext_we, bus_err = 0. cpu_rdata, ext_addr, ext_wdata, ie_reg = 0x00. Timeout counter = 0. HRAM contents are not reset. Reset mid-transaction drops ext_req immediately. No cpu_done is issued for the aborted access.
- Address decode (combinational on cpu_addr):
  - 0000-DFFF EXT
  - E000-FDFF ECHO (ext_addr = addr-0x2000), or UNMAPPED if ECHO_EN=0
  - FE00-FE9F EXT
  - FEA0-FEFF UNMAPPED
  - FF00-FF7F EXT
  - FF80-FFFE HRAM (127 B)
  - FFFF IE
- States: IDLE, EXT_WAIT, RESP. cpu_busy = (state != IDLE).
- IDLE, cpu_req=1:
  - HRAM/IE write: update on this edge, go to RESP.
  - HRAM/IE read: register data into cpu_rdata, go to RESP.
  - UNMAPPED read: cpu_rdata <= 0xFF, go to RESP.
  - UNMAPPED write: discarded, go to RESP.
  - EXT/ECHO: latch ext_addr/ext_we/ext_wdata, ext_req <= 1, counter <= 0, go to EXT_WAIT.
- Internal access latency: cpu_done is high the cycle after acceptance.
- EXT_WAIT:
  - ext_req, ext_addr, ext_we and ext_wdata are held stable.
  - ext_ack=1: capture ext_rdata into cpu_rdata (reads only), ext_req <= 0, go to RESP.
  - Else, counter == TIMEOUT-1: ext_req <= 0, cpu_rdata <= 0xFF (reads), bus_err <= 1, go to RESP.
  - Else counter++.
  - ext_ack and timeout on the same cycle: ack wins, no error.
- RESP: cpu_done=1 for exactly one cycle, then IDLE. cpu_busy stays high in RESP, so a new request is accepted one cycle after cpu_done, never on the same cycle.
- External latency: cpu_done arrives 2 + N cycles after acceptance, where N = cycles before ack (N=0 when ack is present on the first EXT_WAIT cycle).
- cpu_req while busy: ignored, not queued.
- cpu_rdata holds its value until the next read completion. Write completions leave it unchanged.
- bus_err:
  - set by timeout, cleared by err_clr.
  - Timeout and err_clr in the same cycle: set wins.
- IE: all 8 bits are stored and read back as written.

Decomposition:
- sm83_pkg additions:
  - bus_region_t enum: REG_EXT, REG_ECHO, REG_HRAM, REG_IE, REG_UNMAPPED
  - bus_state_t enum: BUS_IDLE, BUS_EXT_WAIT, BUS_RESP
  - Address boundary constants: HRAM_BASE=16'hFF80, IE_ADDR=16'hFFFF, ECHO_BASE=16'hE000, ECHO_END=16'hFDFF, UNMAP_BASE=16'hFEA0, UNMAP_END=16'hFEFF
  - OPEN_BUS=8'hFF
- One sub-module: sm83_hram.
  - 127x8 synchronous-write, registered-read array.
  - 7-bit index = addr-0xFF80.

Test Plan:
- Write 0x5A to FF80, then read FF80 → both cpu_done 1 cycle after accept. Read returns 0x5A, ext_req never asserted.
- Write 0x1F to FFFF → ie_reg=0x1F the cycle after accept. Read FFFF returns 0x1F.
- Read E123 with ext_ack after 3 waits and ext_rdata=0xC3 → ext_addr=0xC123, ext_we=0, cpu_done 5 cycles after accept, cpu_rdata=0xC3.
- Read 0x0100 with ext_ack never asserted (TIMEOUT=16) → ext_req drops after 16 cycles, cpu_rdata=0xFF, bus_err=1. err_clr pulse clears bus_err to 0.
- Read FEA5 → cpu_rdata=0xFF, done after 1 cycle. Write 0x77 to FEA5 → no ext activity. cpu_req asserted while busy → ignored, exactly one cpu_done.
- Assert rst_n=0 mid EXT_WAIT → ext_req=0 immediately, no cpu_done. After release, a write to 0x8000 completes normally with ext_we=1, ext_wdata as issued.
